// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sram_arbiter
// Brief   : Two-requester arbiter/sequencer for the shared SRAM serial engine,
//           with read-data return, one-cycle ack and a completion watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int AW      = 17,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255,
    parameter int PRIO1   = 0
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_ack,
    output logic          r0_err,
    output logic [DW-1:0] r0_rdata,

    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_ack,
    output logic          r1_err,
    output logic [DW-1:0] r1_rdata,

    output logic          eng_start,
    output logic          eng_we,
    output logic [AW-1:0] eng_addr,
    output logic [DW-1:0] eng_wdata,
    output logic          eng_abort,
    input  logic          eng_busy,
    input  logic          eng_done,
    input  logic [DW-1:0] eng_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    localparam logic [15:0] c_to_last = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_grant;
    logic        r_last;
    logic        r_to_pend;
    logic [15:0] r_cnt;

    logic        w_any;
    logic        w_pick;

    assign w_any = r0_req | r1_req;

    generate
        if (PRIO1 != 0) begin : g_fixed_prio
            assign w_pick = r1_req;
        end else begin : g_round_robin
            // On a tie the requester that was not served last goes next.
            assign w_pick = (r0_req && r1_req) ? ~r_last : r1_req;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_grant   <= 1'b0;
            r_last    <= 1'b1;
            r_to_pend <= 1'b0;
            r_cnt     <= 16'd0;
            r0_ack    <= 1'b0;
            r0_err    <= 1'b0;
            r0_rdata  <= '0;
            r1_ack    <= 1'b0;
            r1_err    <= 1'b0;
            r1_rdata  <= '0;
            eng_start <= 1'b0;
            eng_we    <= 1'b0;
            eng_addr  <= '0;
            eng_wdata <= '0;
            eng_abort <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            eng_abort <= 1'b0;
            r0_ack    <= 1'b0;
            r0_err    <= 1'b0;
            r1_ack    <= 1'b0;
            r1_err    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any && !eng_busy) begin
                        r_grant   <= w_pick;
                        eng_we    <= w_pick ? r1_we    : r0_we;
                        eng_addr  <= w_pick ? r1_addr  : r0_addr;
                        eng_wdata <= w_pick ? r1_wdata : r0_wdata;
                        eng_start <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    r_cnt   <= 16'd0;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    if (eng_done) begin
                        if (r_grant) begin
                            r1_ack   <= 1'b1;
                            r1_rdata <= eng_we ? '0 : eng_rdata;
                        end else begin
                            r0_ack   <= 1'b1;
                            r0_rdata <= eng_we ? '0 : eng_rdata;
                        end
                        r_state <= S_ACK;
                    end else if (r_cnt == c_to_last) begin
                        eng_abort <= 1'b1;
                        r_to_pend <= 1'b1;
                        r_state   <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_ACK: begin
                    // A timed-out transfer acks one cycle after the abort strobe.
                    if (r_to_pend) begin
                        r_to_pend <= 1'b0;
                        if (r_grant) begin
                            r1_ack   <= 1'b1;
                            r1_err   <= 1'b1;
                            r1_rdata <= '0;
                        end else begin
                            r0_ack   <= 1'b1;
                            r0_err   <= 1'b1;
                            r0_rdata <= '0;
                        end
                    end else begin
                        r_last  <= r_grant;
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
